// File: rtl/keypad_scanner.sv
// Row-strobed matrix keypad scanner with frame-level debounce and a
// valid/ready key-event output that drops (and flags) presses while an event is pending.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int DWELL    = 2,
  parameter int DEBOUNCE = 3,
  localparam int KW      = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ROWS-1:0] row_drive,
  input  logic [COLS-1:0] col_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [KW-1:0]   number,
  output logic            pressed,
  output logic            overflow
);

  localparam int RW = $clog2(ROWS);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD} state_t;

  logic [DW-1:0] dwell;
  logic [RW-1:0] row_idx;
  logic [1:0]    hit_cnt;
  logic [KW-1:0] hit_key;
  logic          frame_vld, frame_one, frame_none;
  logic [KW-1:0] frame_key;

  state_t        state;
  logic [CW-1:0] cnt, rel;
  logic [KW-1:0] cand;

  logic          sample;
  logic [1:0]    row_hits, tot;
  logic [2:0]    tot_w;
  logic [KW-1:0] row_key, comb_key;
  logic          accept;

  assign sample = (dwell == DW'(DWELL - 1));

  // Hit count saturates at 2: only none/one/many matters for classification.
  always_comb begin
    row_hits = '0;
    row_key  = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_in[c]) begin
        if (row_hits == 2'd0) row_key = KW'(int'(row_idx) * COLS + int'(c));
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
    tot_w    = {1'b0, hit_cnt} + {1'b0, row_hits};
    tot      = (tot_w >= 3'd2) ? 2'd2 : tot_w[1:0];
    comb_key = (hit_cnt == 2'd0) ? row_key : hit_key;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_drive  <= ROWS'(1);
      row_idx    <= '0;
      dwell      <= '0;
      hit_cnt    <= '0;
      hit_key    <= '0;
      frame_vld  <= 1'b0;
      frame_one  <= 1'b0;
      frame_none <= 1'b0;
      frame_key  <= '0;
    end else begin
      frame_vld <= 1'b0;
      if (sample) begin
        dwell     <= '0;
        row_drive <= {row_drive[ROWS-2:0], row_drive[ROWS-1]};
        if (row_idx == RW'(ROWS - 1)) begin
          row_idx    <= '0;
          hit_cnt    <= '0;
          hit_key    <= '0;
          frame_vld  <= 1'b1;
          frame_one  <= (tot == 2'd1);
          frame_none <= (tot == 2'd0);
          frame_key  <= comb_key;
        end else begin
          row_idx <= row_idx + 1'b1;
          hit_cnt <= tot;
          hit_key <= comb_key;
        end
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  assign accept = frame_vld && frame_one &&
                  ((state == S_IDLE && DEBOUNCE == 1) ||
                   (state == S_CONFIRM && frame_key == cand && cnt == CW'(DEBOUNCE - 1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rel       <= '0;
      cand      <= '0;
      out_valid <= 1'b0;
      number    <= '0;
      pressed   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      // An accept coinciding with a handshake reloads rather than overflows.
      if (accept) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          number    <= frame_key;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (frame_vld) begin
        case (state)
          S_IDLE: begin
            if (frame_one) begin
              cand <= frame_key;
              cnt  <= CW'(1);
              if (accept) begin
                state   <= S_HELD;
                rel     <= '0;
                pressed <= 1'b1;
              end else begin
                state <= S_CONFIRM;
              end
            end
          end
          S_CONFIRM: begin
            if (!frame_one) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else if (frame_key != cand) begin
              cand <= frame_key;
              cnt  <= CW'(1);
            end else begin
              cnt <= cnt + 1'b1;
              if (accept) begin
                state   <= S_HELD;
                rel     <= '0;
                pressed <= 1'b1;
              end
            end
          end
          S_HELD: begin
            if (!frame_none) begin
              rel <= '0;
            end else if (rel == CW'(DEBOUNCE - 1)) begin
              state   <= S_IDLE;
              rel     <= '0;
              cnt     <= '0;
              pressed <= 1'b0;
            end else begin
              rel <= rel + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: a physical keypad model drives col_in from row_drive, a
// frame-level debounce model predicts events, and a monitor scores the output channel.
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 3;
  localparam int DWELL    = 2;
  localparam int DEBOUNCE = 3;
  localparam int NK       = ROWS * COLS;
  localparam int KW       = $clog2(NK);
  localparam int FRAME    = ROWS * DWELL;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [ROWS-1:0] row_drive;
  logic [COLS-1:0] col_in;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [KW-1:0]   number;
  logic            pressed;
  logic            overflow;
  logic [NK-1:0]   keys = '0;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .reset(reset), .row_drive(row_drive), .col_in(col_in),
    .out_valid(out_valid), .out_ready(out_ready), .number(number),
    .pressed(pressed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Closed switches connect the strobed row to their columns.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_drive[r]) col_in = col_in | keys[r*COLS +: COLS];
  end

  typedef struct {
    int unsigned t;
    int          v;
  } ev_t;

  ev_t         acc_q[$];
  ev_t         prs_q[$];
  int unsigned cyc = 0;
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Frame-level reference: a key seen alone in DEBOUNCE consecutive frames is
  // accepted; DEBOUNCE consecutive empty frames release it.
  int unsigned base;
  int unsigned frame_no;
  bit          held;
  int          streak, skey, rel;

  task automatic model_reset();
    held = 0; streak = 0; skey = -1; rel = 0; frame_no = 0;
  endtask

  task automatic model_step(input logic [NK-1:0] k);
    int unsigned t;
    int          idx;
    t   = base + FRAME * frame_no + FRAME + 1;
    idx = -1;
    for (int i = 0; i < NK; i++) if (k[i]) idx = i;
    if (!held) begin
      if ($countones(k) == 1) begin
        if (streak > 0 && idx == skey) streak++;
        else begin
          skey   = idx;
          streak = 1;
        end
        if (streak == DEBOUNCE) begin
          acc_q.push_back('{t, idx});
          held = 1; rel = 0; streak = 0;
        end
      end else begin
        streak = 0;
      end
    end else begin
      if (k == '0) begin
        rel++;
        if (rel == DEBOUNCE) held = 0;
      end else begin
        rel = 0;
      end
    end
    prs_q.push_back('{t, int'(held)});
    frame_no++;
  endtask

  task automatic run_frame(input logic [NK-1:0] k, input int unsigned rpct);
    keys = k;
    model_step(k);
    for (int i = 0; i < FRAME; i++) begin
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
    end
  endtask

  task automatic run_frames(input logic [NK-1:0] k, input int n, input int unsigned rpct);
    for (int i = 0; i < n; i++) run_frame(k, rpct);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    acc_q.delete();
    prs_q.delete();
    model_reset();
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    base  = cyc;
  endtask

  function automatic logic [NK-1:0] key(input int i);
    logic [NK-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  // Monitor: scan order, output channel and pressed flag, sampled after each edge.
  initial begin
    bit          rs, rdy, hs, exp_valid, ovf;
    int          exp_num;
    int unsigned scan_base, n;
    ev_t         e;
    exp_valid = 0; exp_num = 0; scan_base = 0;
    forever begin
      @(posedge clk);
      rs  = reset;
      rdy = out_ready;
      #1;
      cyc++;
      if (!rs) begin
        exp_valid = 0; exp_num = 0; scan_base = cyc;
        chk("rst_row_drive", 32'(row_drive), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_number", 32'(number), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
      end else begin
        n = cyc - scan_base;
        chk("row_drive", 32'(row_drive), 32'd1 << ((n / DWELL) % ROWS));
        hs  = exp_valid && rdy;
        ovf = 0;
        while (acc_q.size() > 0 && acc_q[0].t < cyc) begin
          chk("accept_stale", acc_q[0].t, cyc);
          void'(acc_q.pop_front());
        end
        if (acc_q.size() > 0 && acc_q[0].t == cyc) begin
          e = acc_q.pop_front();
          if (!exp_valid || hs) begin
            exp_valid = 1;
            exp_num   = e.v;
          end else begin
            ovf = 1;
          end
        end else if (hs) begin
          exp_valid = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("overflow", 32'(overflow), 32'(ovf));
        if (exp_valid) chk("number", 32'(number), exp_num);
        if (prs_q.size() > 0 && prs_q[0].t == cyc) begin
          e = prs_q.pop_front();
          chk("pressed", 32'(pressed), e.v);
        end
      end
    end
  end

  initial begin
    logic [NK-1:0] k;
    int            r, nf, a, b;
    do_reset(3);
    run_frames('0, 13, 50);                        // idle: no events
    run_frames(key(5), 5, 100);                    // clean press of row 1 col 2
    run_frames('0, DEBOUNCE + 1, 100);
    run_frames(key(0), 2, 100);                    // bounce
    run_frames('0, 1, 100);
    run_frames(key(0), 3, 100);
    run_frames('0, DEBOUNCE + 1, 100);
    run_frames(key(0) | key(6), 6, 100);           // multi-key across rows
    run_frames('0, 2, 100);
    run_frames(key(11), 3, 0);                     // overflow
    run_frames('0, DEBOUNCE, 0);
    run_frames(key(4), 3, 0);
    run_frames('0, DEBOUNCE + 1, 0);
    run_frames('0, 2, 100);
    run_frames(key(7), 2, 100);                    // reset mid-confirm
    do_reset(1);
    run_frames(key(7), 4, 100);
    run_frames('0, DEBOUNCE + 1, 100);
    repeat (60) begin
      r  = $urandom_range(99);
      nf = $urandom_range(1, 5);
      a  = $urandom_range(NK - 1);
      b  = (a + $urandom_range(1, NK - 1)) % NK;
      if (r < 35)      k = '0;
      else if (r < 85) k = key(a);
      else             k = key(a) | key(b);
      run_frames(k, nf, $urandom_range(100));
    end
    run_frames('0, DEBOUNCE + 2, 100);
    repeat (4) @(negedge clk);
    chk("accept_queue_drained", acc_q.size(), 0);
    chk("pressed_queue_drained", prs_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
